// File: rtl/ddc_phase_ctrl.sv
// Phase table + load/settle/resync/wait sequencer for N_CH DDC channels.
// Ports: cfg_* table writes, start/ch_en command, ddc_valid in; phase_*, resync, status out.
module ddc_phase_ctrl #(
  parameter int N_CH       = 4,
  parameter int SETTLE_CYC = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                    s_axis_aclk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [$clog2(N_CH)-1:0] cfg_addr,
  input  logic [19:0]             cfg_pinc,
  input  logic [19:0]             cfg_poff,
  input  logic [N_CH-1:0]         ch_en,
  input  logic                    start,
  input  logic [N_CH-1:0]         ddc_valid,
  output logic [63:0]             phase_tdata,
  output logic [N_CH-1:0]         phase_tvalid,
  output logic                    resync,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [N_CH-1:0]         err_mask,
  output logic                    cfg_dropped
);

  localparam int AW   = $clog2(N_CH);
  localparam int CMAX = (SETTLE_CYC > TIMEOUT) ? SETTLE_CYC : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RESYNC,
    S_WAIT
  } state_t;

  state_t          state, state_d;
  logic [AW-1:0]   idx, idx_d, ridx;
  logic [CW-1:0]   cnt, cnt_d;
  logic [N_CH-1:0] en_q, en_d, ren;
  logic [N_CH-1:0] seen, seen_d, seen_n;
  logic [N_CH-1:0] tvalid_d, err_mask_d;
  logic [63:0]     tdata_d;
  logic            resync_d, busy_d, done_d, err_d, drop_d;
  logic            fire, addr_ok;
  logic [39:0]     tbl [N_CH];

  if ((1 << AW) == N_CH) begin : g_pow2
    assign addr_ok = 1'b1;
  end else begin : g_npow2
    assign addr_ok = {1'b0, cfg_addr} < (AW + 1)'(N_CH);
  end

  // Table has no reset so contents survive a mid-sequence rst.
  always_ff @(posedge s_axis_aclk) begin
    if (cfg_we && !busy && addr_ok)
      tbl[cfg_addr] <= {cfg_poff, cfg_pinc};
  end

  // Output regs are loaded one cycle ahead of the beat they
  // present, so the comb side always looks at the next index.
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    cnt_d      = cnt;
    en_d       = en_q;
    seen_d     = seen;
    seen_n     = seen | (ddc_valid & en_q);
    err_mask_d = err_mask;
    drop_d     = cfg_dropped | (cfg_we & busy);
    resync_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    tvalid_d   = '0;
    tdata_d    = '0;
    fire       = 1'b0;
    ridx       = '0;
    ren        = en_q;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          en_d       = ch_en;
          err_mask_d = '0;
          drop_d     = 1'b0;
          if (ch_en == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_LOAD;
            idx_d   = '0;
            ren     = ch_en;
            fire    = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (idx == AW'(N_CH - 1)) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else begin
          idx_d = idx + 1'b1;
          ridx  = idx + 1'b1;
          fire  = 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt == CW'(SETTLE_CYC - 1)) begin
          state_d  = S_RESYNC;
          resync_d = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_RESYNC: begin
        seen_d  = '0;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        seen_d = seen_n;
        // Completion is checked first so it wins a tie with timeout.
        if (seen_n == en_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_d      = 1'b1;
          err_mask_d = en_q & ~seen_n;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fire && ren[ridx]) begin
      tvalid_d = {{(N_CH-1){1'b0}}, 1'b1} << ridx;
      tdata_d  = {12'h000, tbl[ridx][39:20], 12'h000, tbl[ridx][19:0]};
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge s_axis_aclk) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      cnt          <= '0;
      en_q         <= '0;
      seen         <= '0;
      phase_tdata  <= '0;
      phase_tvalid <= '0;
      resync       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_mask     <= '0;
      cfg_dropped  <= 1'b0;
    end else begin
      state        <= state_d;
      idx          <= idx_d;
      cnt          <= cnt_d;
      en_q         <= en_d;
      seen         <= seen_d;
      phase_tdata  <= tdata_d;
      phase_tvalid <= tvalid_d;
      resync       <= resync_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
      err_mask     <= err_mask_d;
      cfg_dropped  <= drop_d;
    end
  end

endmodule

// File: doc/ddc_phase_ctrl.md
# ddc_phase_ctrl

Sequences phase configuration and resynchronisation for a bank of N_CH quad-lane DDC tone channels. Holds a per-channel phase table (20-bit increment, 20-bit offset) written from the register side and, on a start command, pushes each enabled channel's phase word in order. It then issues one common resync pulse and waits for every enabled DDC to report output valid, with a bounded timeout. It sits between the AXI-Lite register block and the DDC instances' phase/resync inputs.

## Interface
- N_CH, 4: number of DDC channels (2..16)
- SETTLE_CYC, 8: idle cycles between last phase beat and resync (≥ 4, covers DDC phase-input latency)
- TIMEOUT, 64: maximum cycles waited for DDC valid after resync (≥ 1)

- s_axis_aclk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  write phase table entry
- cfg_addr  in  clog2(N_CH)  table index
- cfg_pinc  in  20  phase increment
- cfg_poff  in  20  phase offset
- ch_en  in  N_CH  channel enable mask, sampled at start
- start  in  1  single-cycle command
- ddc_valid  in  N_CH  per-channel DDC valid_out
- phase_tdata  out  64  {12'b0, poff, 12'b0, pinc}, shared by all channels
- phase_tvalid  out  N_CH  one-hot per-channel phase strobe
- resync  out  1  common resync pulse
- busy  out  1  sequence in progress
- done  out  1  one-cycle success pulse
- err  out  1  one-cycle timeout pulse
- err_mask  out  N_CH  enabled channels that never reported valid (held until next start)
- cfg_dropped  out  1  sticky: a cfg_we arrived while busy

## Operation
- Phase table: N_CH × 40-bit registers, no reset. cfg_we writes when not busy; cfg_addr ≥ N_CH is ignored. A write while busy is dropped and sets cfg_dropped; cfg_dropped clears on the next accepted start.
- FSM: IDLE → LOAD → SETTLE → RESYNC → WAIT → IDLE.
- IDLE: start accepted only here. On start, latch ch_en into en_q; clear err_mask and cfg_dropped. If ch_en == 0, pulse done next cycle and stay in IDLE; no phase_tvalid, no resync. Otherwise go to LOAD with idx = 0.
- LOAD: exactly N_CH cycles, idx 0..N_CH-1 ascending. If en_q[idx] is set, drive phase_tdata from table[idx] and phase_tvalid[idx] = 1. Disabled indices give an idle cycle with phase_tvalid = 0. No tready exists; each beat is fire-and-forget.
- SETTLE: count SETTLE_CYC cycles.
- RESYNC: resync = 1 for exactly one cycle; clear seen mask.
- WAIT: every cycle, seen |= ddc_valid & en_q. If seen == en_q, pulse done and return to IDLE. If TIMEOUT cycles elapse without completion, pulse err, set err_mask = en_q & ~seen, and return to IDLE. If completion and timeout occur in the same cycle, completion wins.
- Table writes made during IDLE take effect at the next start. The table contents at LOAD time are what get sent.
- start while busy: ignored; no flag.

## Timing
- All outputs registered. Reset values: phase_tdata = 0, phase_tvalid = 0, resync = 0, busy = 0, done = 0, err = 0, err_mask = 0, cfg_dropped = 0; FSM = IDLE; counters = 0.
- start high in cycle 0 → busy = 1 from cycle 1. phase_tvalid[k] is high in cycle 1+k.
- resync is high in cycle 1+N_CH+SETTLE_CYC.
- ddc_valid is sampled starting the cycle after resync, for cycles r+1 … r+TIMEOUT (r = resync cycle).
- done/err is high the cycle after the completing/final sample. busy drops in that same cycle.
- ch_en == 0: done in cycle 1; busy stays 0.
- rst mid-sequence: all outputs return to reset values on the next edge; no done/err is generated. The phase table is preserved.

## Test plan
- N_CH=4, table[i] = {poff=i·0x100, pinc=0x1000+i}, ch_en=0xF, start at cycle 0 → phase_tvalid = 0x1,0x2,0x4,0x8 in cycles 1–4 with phase_tdata[19:0] = 0x1000..0x1003 and [51:32] = 0x000..0x300; resync in cycle 13; drive ddc_valid = 0xF at cycle 20 → done in cycle 21, busy low.
- ch_en=0x5 → phase_tvalid only in cycles 1 and 3, idle in cycles 2 and 4; ddc_valid = 0x5 completes. ddc_valid[1] high alone is ignored.
- ch_en=0x3, only ddc_valid[0] ever asserted → err in cycle 13+64+1 = 78, err_mask = 0x2, done stays 0.
- cfg_we during LOAD → table unchanged (verify on the next start), cfg_dropped = 1; next start clears it. start during WAIT → no effect.
- ch_en=0 → done in cycle 1, no phase_tvalid, no resync. rst asserted in cycle 3 of LOAD → phase_tvalid = 0 and busy = 0 from cycle 4, no resync or done, table intact on the next run.
